// File: rtl/sram_1rw1r_arbiter.sv
// rtl/sram_1rw1r_arbiter.sv - two-master arbiter in front of a 1RW+1R SRAM macro with fixed 2-cycle read latency
// Optional stall counter output is enabled by defining SRAM_ARB_STATS_EN.
module sram_1rw1r_arbiter #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 16,
    parameter int NUM_WMASKS = DATA_WIDTH / 8
) (
    input  logic                  clk0,
    input  logic                  rst0,

    input  logic                  m0_req_valid,
    output logic                  m0_req_ready,
    input  logic                  m0_req_we,
    input  logic [NUM_WMASKS-1:0] m0_req_wmask,
    input  logic [ADDR_WIDTH-1:0] m0_req_addr,
    input  logic [DATA_WIDTH-1:0] m0_req_wdata,
    output logic                  m0_rsp_valid,
    output logic [DATA_WIDTH-1:0] m0_rsp_rdata,

    input  logic                  m1_req_valid,
    output logic                  m1_req_ready,
    input  logic                  m1_req_we,
    input  logic [NUM_WMASKS-1:0] m1_req_wmask,
    input  logic [ADDR_WIDTH-1:0] m1_req_addr,
    input  logic [DATA_WIDTH-1:0] m1_req_wdata,
    output logic                  m1_rsp_valid,
    output logic [DATA_WIDTH-1:0] m1_rsp_rdata,

    output logic                  csb0,
    output logic                  web0,
    output logic [NUM_WMASKS-1:0] wmask0,
    output logic [ADDR_WIDTH-1:0] addr0,
    output logic [DATA_WIDTH-1:0] din0,
    input  logic [DATA_WIDTH-1:0] dout0,
    output logic                  csb1,
    output logic [ADDR_WIDTH-1:0] addr1,
    input  logic [DATA_WIDTH-1:0] dout1
`ifdef SRAM_ARB_STATS_EN
    ,
    output logic [15:0]           stall_cnt
`endif
);

    logic                  r_rr;
    logic                  r_csb0;
    logic                  r_web0;
    logic [NUM_WMASKS-1:0] r_wmask0;
    logic [ADDR_WIDTH-1:0] r_addr0;
    logic [DATA_WIDTH-1:0] r_din0;
    logic                  r_csb1;
    logic [ADDR_WIDTH-1:0] r_addr1;

    logic                  r_p0_tag_v1, r_p0_tag_m1, r_p0_tag_v2, r_p0_tag_m2;
    logic                  r_p1_tag_v1, r_p1_tag_m1, r_p1_tag_v2, r_p1_tag_m2;

    logic                  r_rsp_valid0, r_rsp_valid1;
    logic [DATA_WIDTH-1:0] r_rsp_rdata0, r_rsp_rdata1;

    logic                  w_wr0, w_wr1, w_rd0, w_rd1;
    logic                  w_same_addr;
    logic                  w_gnt0, w_gnt1;
    logic                  w_rg0, w_rg1;
    logic                  w_wr_en, w_wr_sel;
    logic [NUM_WMASKS-1:0] w_wr_mask;
    logic [DATA_WIDTH-1:0] w_wr_data;
    logic                  w_p0_rd, w_p0_rd_sel;
    logic                  w_p1_rd, w_p1_rd_sel;
    logic [ADDR_WIDTH-1:0] w_p0_addr, w_p1_addr;
    logic                  w_hit0_p0, w_hit0_p1, w_hit1_p0, w_hit1_p1;

    assign w_wr0       = m0_req_valid &  m0_req_we;
    assign w_rd0       = m0_req_valid & ~m0_req_we;
    assign w_wr1       = m1_req_valid &  m1_req_we;
    assign w_rd1       = m1_req_valid & ~m1_req_we;
    assign w_same_addr = (m0_req_addr == m1_req_addr);

    // A read that hits the address being written this cycle is held so the
    // macro never sees a same-address write/read in one cycle.
    always_comb begin
        w_gnt0 = 1'b0;
        w_gnt1 = 1'b0;
        if (!rst0) begin
            if (w_wr0 && w_wr1) begin
                w_gnt0 = ~r_rr;
                w_gnt1 =  r_rr;
            end else if (w_wr0 && w_rd1) begin
                w_gnt0 = 1'b1;
                w_gnt1 = ~w_same_addr;
            end else if (w_rd0 && w_wr1) begin
                w_gnt0 = ~w_same_addr;
                w_gnt1 = 1'b1;
            end else begin
                w_gnt0 = m0_req_valid;
                w_gnt1 = m1_req_valid;
            end
        end
    end

    assign m0_req_ready = w_gnt0;
    assign m1_req_ready = w_gnt1;

    assign w_rg0     = w_gnt0 & ~m0_req_we;
    assign w_rg1     = w_gnt1 & ~m1_req_we;
    assign w_wr_en   = (w_gnt0 & m0_req_we) | (w_gnt1 & m1_req_we);
    assign w_wr_sel  = w_gnt1 & m1_req_we;
    assign w_wr_mask = w_wr_sel ? m1_req_wmask : m0_req_wmask;
    assign w_wr_data = w_wr_sel ? m1_req_wdata : m0_req_wdata;

    // Port 0 carries a read only when both masters read; the favoured one takes it.
    assign w_p0_rd     = w_rg0 & w_rg1;
    assign w_p0_rd_sel = r_rr;
    assign w_p1_rd     = w_rg0 | w_rg1;
    assign w_p1_rd_sel = (w_rg0 & w_rg1) ? ~r_rr : w_rg1;

    assign w_p0_addr = w_wr_en ? (w_wr_sel    ? m1_req_addr : m0_req_addr)
                               : (w_p0_rd_sel ? m1_req_addr : m0_req_addr);
    assign w_p1_addr = w_p1_rd_sel ? m1_req_addr : m0_req_addr;

    always_ff @(posedge clk0) begin
        if (rst0) begin
            r_rr <= 1'b0;
        end else if (w_wr0 && w_wr1) begin
            r_rr <= ~r_rr;
        end
    end

    always_ff @(posedge clk0) begin
        if (rst0) begin
            r_csb0   <= 1'b1;
            r_web0   <= 1'b1;
            r_wmask0 <= '0;
            r_addr0  <= '0;
            r_din0   <= '0;
            r_csb1   <= 1'b1;
            r_addr1  <= '0;
        end else begin
            r_csb0   <= ~(w_wr_en | w_p0_rd);
            r_web0   <= ~w_wr_en;
            r_wmask0 <= w_wr_en ? w_wr_mask : '0;
            r_addr0  <= (w_wr_en | w_p0_rd) ? w_p0_addr : '0;
            r_din0   <= w_wr_en ? w_wr_data : '0;
            r_csb1   <= ~w_p1_rd;
            r_addr1  <= w_p1_rd ? w_p1_addr : '0;
        end
    end

    assign csb0   = r_csb0;
    assign web0   = r_web0;
    assign wmask0 = r_wmask0;
    assign addr0  = r_addr0;
    assign din0   = r_din0;
    assign csb1   = r_csb1;
    assign addr1  = r_addr1;

    // Tags follow each read through the macro so the returning word can be
    // routed back to whichever master issued it.
    always_ff @(posedge clk0) begin
        if (rst0) begin
            r_p0_tag_v1 <= 1'b0;
            r_p0_tag_m1 <= 1'b0;
            r_p0_tag_v2 <= 1'b0;
            r_p0_tag_m2 <= 1'b0;
            r_p1_tag_v1 <= 1'b0;
            r_p1_tag_m1 <= 1'b0;
            r_p1_tag_v2 <= 1'b0;
            r_p1_tag_m2 <= 1'b0;
        end else begin
            r_p0_tag_v1 <= w_p0_rd;
            r_p0_tag_m1 <= w_p0_rd_sel;
            r_p0_tag_v2 <= r_p0_tag_v1;
            r_p0_tag_m2 <= r_p0_tag_m1;
            r_p1_tag_v1 <= w_p1_rd;
            r_p1_tag_m1 <= w_p1_rd_sel;
            r_p1_tag_v2 <= r_p1_tag_v1;
            r_p1_tag_m2 <= r_p1_tag_m1;
        end
    end

    assign w_hit0_p0 = r_p0_tag_v2 & ~r_p0_tag_m2;
    assign w_hit0_p1 = r_p1_tag_v2 & ~r_p1_tag_m2;
    assign w_hit1_p0 = r_p0_tag_v2 &  r_p0_tag_m2;
    assign w_hit1_p1 = r_p1_tag_v2 &  r_p1_tag_m2;

    always_ff @(posedge clk0) begin
        if (rst0) begin
            r_rsp_valid0 <= 1'b0;
            r_rsp_valid1 <= 1'b0;
            r_rsp_rdata0 <= '0;
            r_rsp_rdata1 <= '0;
        end else begin
            r_rsp_valid0 <= w_hit0_p0 | w_hit0_p1;
            r_rsp_valid1 <= w_hit1_p0 | w_hit1_p1;
            if (w_hit0_p0) begin
                r_rsp_rdata0 <= dout0;
            end else if (w_hit0_p1) begin
                r_rsp_rdata0 <= dout1;
            end
            if (w_hit1_p0) begin
                r_rsp_rdata1 <= dout0;
            end else if (w_hit1_p1) begin
                r_rsp_rdata1 <= dout1;
            end
        end
    end

    assign m0_rsp_valid = r_rsp_valid0;
    assign m0_rsp_rdata = r_rsp_rdata0;
    assign m1_rsp_valid = r_rsp_valid1;
    assign m1_rsp_rdata = r_rsp_rdata1;

`ifdef SRAM_ARB_STATS_EN
    logic [15:0] r_stall_cnt;
    logic        w_stall;

    assign w_stall = (m0_req_valid & ~m0_req_ready) | (m1_req_valid & ~m1_req_ready);

    always_ff @(posedge clk0) begin
        if (rst0) begin
            r_stall_cnt <= '0;
        end else if (w_stall && (r_stall_cnt != 16'hFFFF)) begin
            r_stall_cnt <= r_stall_cnt + 16'd1;
        end
    end

    assign stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_sram_1rw1r_arbiter.sv
// tb/tb_sram_1rw1r_arbiter.sv - self-checking bench for sram_1rw1r_arbiter with a behavioural macro and reference model
module tb_sram_1rw1r_arbiter;

    localparam int AW = 4;
    localparam int DW = 16;
    localparam int NM = 2;

    logic          clk0 = 1'b0;
    logic          rst0 = 1'b1;
    logic          m0_req_valid = 1'b0, m0_req_we = 1'b0;
    logic [NM-1:0] m0_req_wmask = '0;
    logic [AW-1:0] m0_req_addr = '0;
    logic [DW-1:0] m0_req_wdata = '0;
    logic          m1_req_valid = 1'b0, m1_req_we = 1'b0;
    logic [NM-1:0] m1_req_wmask = '0;
    logic [AW-1:0] m1_req_addr = '0;
    logic [DW-1:0] m1_req_wdata = '0;
    logic          m0_req_ready, m1_req_ready, m0_rsp_valid, m1_rsp_valid;
    logic [DW-1:0] m0_rsp_rdata, m1_rsp_rdata;
    logic          csb0, web0, csb1;
    logic [NM-1:0] wmask0;
    logic [AW-1:0] addr0, addr1;
    logic [DW-1:0] din0;
    logic [DW-1:0] dout0 = '0;
    logic [DW-1:0] dout1 = '0;

    always #5 clk0 = ~clk0;

    sram_1rw1r_arbiter dut (
        .clk0(clk0), .rst0(rst0),
        .m0_req_valid(m0_req_valid), .m0_req_ready(m0_req_ready), .m0_req_we(m0_req_we),
        .m0_req_wmask(m0_req_wmask), .m0_req_addr(m0_req_addr), .m0_req_wdata(m0_req_wdata),
        .m0_rsp_valid(m0_rsp_valid), .m0_rsp_rdata(m0_rsp_rdata),
        .m1_req_valid(m1_req_valid), .m1_req_ready(m1_req_ready), .m1_req_we(m1_req_we),
        .m1_req_wmask(m1_req_wmask), .m1_req_addr(m1_req_addr), .m1_req_wdata(m1_req_wdata),
        .m1_rsp_valid(m1_rsp_valid), .m1_rsp_rdata(m1_rsp_rdata),
        .csb0(csb0), .web0(web0), .wmask0(wmask0), .addr0(addr0), .din0(din0), .dout0(dout0),
        .csb1(csb1), .addr1(addr1), .dout1(dout1)
    );

    // Macro: pins latched at posedge, write and read performed at negedge.
    logic [DW-1:0] ram [16];
    logic          l_csb0 = 1'b1, l_web0 = 1'b1, l_csb1 = 1'b1;
    logic [NM-1:0] l_wmask0 = '0;
    logic [AW-1:0] l_addr0 = '0, l_addr1 = '0;
    logic [DW-1:0] l_din0 = '0;

    always @(posedge clk0) begin
        l_csb0   <= csb0;
        l_web0   <= web0;
        l_wmask0 <= wmask0;
        l_addr0  <= addr0;
        l_din0   <= din0;
        l_csb1   <= csb1;
        l_addr1  <= addr1;
    end

    always @(negedge clk0) begin
        if (l_csb0 === 1'b0 && l_web0 === 1'b0) begin
            for (int b = 0; b < NM; b++)
                if (l_wmask0[b]) ram[l_addr0][8*b +: 8] <= l_din0[8*b +: 8];
        end
        if (l_csb0 === 1'b0 && l_web0 === 1'b1) dout0 <= ram[l_addr0];
        if (l_csb1 === 1'b0) dout1 <= ram[l_addr1];
    end

    // Reference model: expected memory contents plus a list of responses due at given cycles.
    typedef struct {
        int            due;
        bit            m;
        logic [DW-1:0] d;
    } rsp_t;

    logic [DW-1:0] ref_mem [16];
    rsp_t          pend [$];
    bit            rr_m = 1'b0;
    int            cyc = 0;
    int            n_pass = 0;
    int            n_checks = 0;

    logic [1:0]    obs_rdy, exp_rdy, obs_rv, exp_rv;
    logic [DW-1:0] obs_rd0, obs_rd1, exp_rd0, exp_rd1;
    logic [35:0]   obs_vec, exp_vec;
    logic          obs_csb0, obs_web0, obs_csb1;
    logic [AW-1:0] obs_addr0, obs_addr1;

    function automatic logic [1:0] model_grant();
        bit w0 = m0_req_valid && m0_req_we;
        bit w1 = m1_req_valid && m1_req_we;
        bit r0 = m0_req_valid && !m0_req_we;
        bit r1 = m1_req_valid && !m1_req_we;
        if (rst0) return 2'b00;
        if (w0 && w1) return rr_m ? 2'b01 : 2'b10;
        if (w0 && r1) return {1'b1, m0_req_addr != m1_req_addr};
        if (r0 && w1) return {m0_req_addr != m1_req_addr, 1'b1};
        return {m0_req_valid, m1_req_valid};
    endfunction

    task automatic model_commit(input logic [1:0] g);
        cyc++;
        if (rst0) begin
            pend.delete();
            rr_m = 1'b0;
            return;
        end
        if (g[1] && !m0_req_we) pend.push_back('{cyc + 2, 1'b0, ref_mem[m0_req_addr]});
        if (g[0] && !m1_req_we) pend.push_back('{cyc + 2, 1'b1, ref_mem[m1_req_addr]});
        for (int b = 0; b < NM; b++) begin
            if (g[1] && m0_req_we && m0_req_wmask[b]) ref_mem[m0_req_addr][8*b +: 8] = m0_req_wdata[8*b +: 8];
            if (g[0] && m1_req_we && m1_req_wmask[b]) ref_mem[m1_req_addr][8*b +: 8] = m1_req_wdata[8*b +: 8];
        end
        if (m0_req_valid && m0_req_we && m1_req_valid && m1_req_we) rr_m = g[1];
    endtask

    // One clock cycle: inputs already set; records observations and model expectations.
    task automatic drive_cycle();
        #1;
        obs_rdy = {m0_req_ready, m1_req_ready};
        exp_rdy = model_grant();
        @(posedge clk0);
        model_commit(exp_rdy);
        @(negedge clk0);
        obs_rv  = {m0_rsp_valid, m1_rsp_valid};
        obs_rd0 = m0_rsp_valid ? m0_rsp_rdata : '0;
        obs_rd1 = m1_rsp_valid ? m1_rsp_rdata : '0;
        exp_rv = 2'b00; exp_rd0 = '0; exp_rd1 = '0;
        foreach (pend[i]) begin
            if (pend[i].due == cyc) begin
                if (!pend[i].m) begin exp_rv[1] = 1'b1; exp_rd0 = pend[i].d; end
                else            begin exp_rv[0] = 1'b1; exp_rd1 = pend[i].d; end
            end
        end
        pend = pend.find(item) with (item.due > cyc);
        obs_vec = {obs_rdy, obs_rv, obs_rd0, obs_rd1};
        exp_vec = {exp_rdy, exp_rv, exp_rd0, exp_rd1};
        obs_csb0 = csb0; obs_web0 = web0; obs_addr0 = addr0;
        obs_csb1 = csb1; obs_addr1 = addr1;
    endtask

    task automatic set_m0(input logic v, input logic we, input logic [AW-1:0] a,
                          input logic [DW-1:0] d, input logic [NM-1:0] m);
        m0_req_valid = v; m0_req_we = we; m0_req_addr = a; m0_req_wdata = d; m0_req_wmask = m;
    endtask

    task automatic set_m1(input logic v, input logic we, input logic [AW-1:0] a,
                          input logic [DW-1:0] d, input logic [NM-1:0] m);
        m1_req_valid = v; m1_req_we = we; m1_req_addr = a; m1_req_wdata = d; m1_req_wmask = m;
    endtask

    task automatic test_reset();
        rst0 = 1'b1;
        set_m0(1'b1, 1'b0, 4'd3, 16'h0, 2'b00);
        set_m1(1'b1, 1'b1, 4'd5, 16'hBEEF, 2'b11);
        for (int i = 0; i < 2; i++) begin
            drive_cycle();
            if ({obs_rdy, obs_rv, obs_csb0, obs_web0, obs_csb1} !== 7'b0000111)
                $display("FAIL reset cycle %0d: rdy/rv/csb0/web0/csb1 got %b want 0000111", i,
                         {obs_rdy, obs_rv, obs_csb0, obs_web0, obs_csb1});
            else n_pass++;
            n_checks++;
        end
        rst0 = 1'b0;
        set_m0(1'b0, 1'b0, 4'd0, 16'h0, 2'b00);
        set_m1(1'b0, 1'b0, 4'd0, 16'h0, 2'b00);
        drive_cycle();
        if ({obs_csb0, obs_web0, obs_csb1, obs_rv} !== 5'b11100)
            $display("FAIL idle_after_reset: got %b want 11100", {obs_csb0, obs_web0, obs_csb1, obs_rv});
        else n_pass++;
        n_checks++;
    endtask

    task automatic test_fill();
        for (int a = 0; a < 16; a++) begin
            set_m0(1'b1, 1'b1, 4'(a), 16'($urandom), 2'b11);
            drive_cycle();
            if (obs_vec !== exp_vec) $display("FAIL fill addr %0d: got %h want %h", a, obs_vec, exp_vec);
            else n_pass++;
            n_checks++;
        end
        set_m0(1'b0, 1'b0, 4'd0, 16'h0, 2'b00);
    endtask

    task automatic test_write_read();
        set_m0(1'b1, 1'b1, 4'd3, 16'hA5C3, 2'b11);
        drive_cycle();
        set_m0(1'b1, 1'b0, 4'd3, 16'h0, 2'b00);
        drive_cycle();
        if (obs_vec !== exp_vec) $display("FAIL write_read issue: got %h want %h", obs_vec, exp_vec);
        else n_pass++;
        n_checks++;
        set_m0(1'b0, 1'b0, 4'd0, 16'h0, 2'b00);
        for (int i = 0; i < 3; i++) begin
            drive_cycle();
            if (obs_vec !== exp_vec) $display("FAIL write_read drain %0d: got %h want %h", i, obs_vec, exp_vec);
            else n_pass++;
            n_checks++;
            if (i == 1) begin
                if ({obs_rv[1], obs_rd0} !== {1'b1, 16'hA5C3})
                    $display("FAIL write_read data: got valid %b data %h want 1 a5c3", obs_rv[1], obs_rd0);
                else n_pass++;
                n_checks++;
            end
        end
    endtask

    task automatic test_collision();
        set_m0(1'b1, 1'b1, 4'd5, 16'h0F0F, 2'b11);
        drive_cycle();
        set_m0(1'b1, 1'b1, 4'd5, 16'h1234, 2'b11);
        set_m1(1'b1, 1'b0, 4'd5, 16'h0, 2'b00);
        drive_cycle();
        if (obs_rdy !== 2'b10) $display("FAIL collision hold: ready got %b want 10", obs_rdy);
        else n_pass++;
        n_checks++;
        set_m0(1'b0, 1'b0, 4'd0, 16'h0, 2'b00);
        drive_cycle();
        if (obs_rdy !== 2'b01) $display("FAIL collision retry: ready got %b want 01", obs_rdy);
        else n_pass++;
        n_checks++;
        set_m1(1'b0, 1'b0, 4'd0, 16'h0, 2'b00);
        for (int i = 0; i < 3; i++) begin
            drive_cycle();
            if (obs_vec !== exp_vec) $display("FAIL collision drain %0d: got %h want %h", i, obs_vec, exp_vec);
            else n_pass++;
            n_checks++;
            if (i == 1) begin
                if ({obs_rv[0], obs_rd1} !== {1'b1, 16'h1234})
                    $display("FAIL collision data: got valid %b data %h want 1 1234", obs_rv[0], obs_rd1);
                else n_pass++;
                n_checks++;
            end
        end
    endtask

    task automatic test_write_write();
        for (int i = 0; i < 4; i++) begin
            set_m0(1'b1, 1'b1, 4'd1, 16'h1100 + 16'(i), 2'b11);
            set_m1(1'b1, 1'b1, 4'd2, 16'h2200 + 16'(i), 2'b11);
            drive_cycle();
            if ({obs_rdy, obs_csb0, obs_web0, obs_addr0} !==
                {((i % 2) == 0) ? 2'b10 : 2'b01, 2'b00, ((i % 2) == 0) ? 4'd1 : 4'd2})
                $display("FAIL write_write cycle %0d: rdy/csb0/web0/addr0 got %b", i,
                         {obs_rdy, obs_csb0, obs_web0, obs_addr0});
            else n_pass++;
            n_checks++;
        end
        set_m0(1'b1, 1'b0, 4'd1, 16'h0, 2'b00);
        set_m1(1'b1, 1'b0, 4'd2, 16'h0, 2'b00);
        drive_cycle();
        set_m0(1'b0, 1'b0, 4'd0, 16'h0, 2'b00);
        set_m1(1'b0, 1'b0, 4'd0, 16'h0, 2'b00);
        for (int i = 0; i < 3; i++) begin
            drive_cycle();
            if (i == 1) begin
                if ({obs_rv, obs_rd0, obs_rd1} !== {2'b11, 16'h1102, 16'h2203})
                    $display("FAIL write_write readback: got %h want 3 1102 2203", {obs_rv, obs_rd0, obs_rd1});
                else n_pass++;
                n_checks++;
            end
        end
    endtask

    task automatic test_read_read();
        set_m0(1'b1, 1'b0, 4'd7, 16'h0, 2'b00);
        set_m1(1'b1, 1'b0, 4'd9, 16'h0, 2'b00);
        drive_cycle();
        if ({obs_rdy, obs_csb0, obs_addr0, obs_csb1, obs_addr1} !== {2'b11, 1'b0, 4'd7, 1'b0, 4'd9})
            $display("FAIL read_read pins: got %b want 11_0_0111_0_1001",
                     {obs_rdy, obs_csb0, obs_addr0, obs_csb1, obs_addr1});
        else n_pass++;
        n_checks++;
        set_m0(1'b0, 1'b0, 4'd0, 16'h0, 2'b00);
        set_m1(1'b0, 1'b0, 4'd0, 16'h0, 2'b00);
        for (int i = 0; i < 3; i++) begin
            drive_cycle();
            if (obs_vec !== exp_vec) $display("FAIL read_read drain %0d: got %h want %h", i, obs_vec, exp_vec);
            else n_pass++;
            n_checks++;
        end
    endtask

    task automatic test_partial();
        set_m0(1'b1, 1'b1, 4'd4, 16'hFFFF, 2'b11);
        drive_cycle();
        set_m0(1'b1, 1'b1, 4'd4, 16'h0000, 2'b01);
        drive_cycle();
        set_m0(1'b1, 1'b0, 4'd4, 16'h0, 2'b00);
        drive_cycle();
        set_m0(1'b0, 1'b0, 4'd0, 16'h0, 2'b00);
        for (int i = 0; i < 3; i++) begin
            drive_cycle();
            if (i == 1) begin
                if ({obs_rv[1], obs_rd0} !== {1'b1, 16'hFF00})
                    $display("FAIL partial data: got valid %b data %h want 1 ff00", obs_rv[1], obs_rd0);
                else n_pass++;
                n_checks++;
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            set_m0(($urandom_range(0, 9) < 7), 1'($urandom), 4'($urandom_range(0, 3)), 16'($urandom), 2'($urandom));
            set_m1(($urandom_range(0, 9) < 7), 1'($urandom), 4'($urandom_range(0, 3)), 16'($urandom), 2'($urandom));
            drive_cycle();
            if (obs_vec !== exp_vec) $display("FAIL random cycle %0d: got %h want %h", i, obs_vec, exp_vec);
            else n_pass++;
            n_checks++;
        end
        set_m0(1'b0, 1'b0, 4'd0, 16'h0, 2'b00);
        set_m1(1'b0, 1'b0, 4'd0, 16'h0, 2'b00);
        for (int i = 0; i < 3; i++) begin
            drive_cycle();
            if (obs_vec !== exp_vec) $display("FAIL random drain %0d: got %h want %h", i, obs_vec, exp_vec);
            else n_pass++;
            n_checks++;
        end
    endtask

    task automatic test_reset_midflight();
        set_m0(1'b1, 1'b0, 4'd1, 16'h0, 2'b00);
        set_m1(1'b1, 1'b0, 4'd2, 16'h0, 2'b00);
        drive_cycle();
        rst0 = 1'b1;
        set_m0(1'b0, 1'b0, 4'd0, 16'h0, 2'b00);
        set_m1(1'b0, 1'b0, 4'd0, 16'h0, 2'b00);
        drive_cycle();
        rst0 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive_cycle();
            if ({obs_rv, obs_csb0, obs_csb1} !== 4'b0011)
                $display("FAIL reset_midflight %0d: rv/csb0/csb1 got %b want 0011", i, {obs_rv, obs_csb0, obs_csb1});
            else n_pass++;
            n_checks++;
        end
    endtask

    initial begin
        @(negedge clk0);
        test_reset();
        test_fill();
        test_write_read();
        test_collision();
        test_write_write();
        test_read_read();
        test_partial();
        test_random();
        test_reset_midflight();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
